// File: rtl/mem_rw_bank.sv
// Single-clock memory bank: one byte-enabled write port, one registered read port,
// selectable read-during-write policy and an optional zero-fill after reset.
module mem_rw_bank #(
    parameter int DATA_W         = 8,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter bit RDW_MODE       = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ready,
    output logic                init_busy,
    output logic                err
);
    // state | meaning
    // CLEAR | zero-filling the array one word per cycle, requests ignored
    // RUN   | servicing one read and one write per cycle

    localparam int                NBYTES    = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_oor, rd_oor, wr_acc, rd_acc, wr_hit;
    logic [DATA_W-1:0]   rd_word, rd_merged;

    // ready/init_busy decode straight from the state flop, so they stay registered
    assign ready     = (state == RUN);
    assign init_busy = (state == CLEAR);

    assign wr_oor = {1'b0, wr_addr} >= DEPTH_X;
    assign rd_oor = {1'b0, rd_addr} >= DEPTH_X;
    assign wr_acc = ready && wr_en;
    assign rd_acc = ready && rd_en;
    assign wr_hit = wr_acc && !wr_oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == CLEAR) begin
            if (ptr == LAST_ADDR) begin
                state_nxt = RUN;
                ptr_nxt   = '0;
            end else begin
                ptr_nxt = ptr + ADDR_W'(1);
            end
        end
    end

    // array contents are deliberately not reset; the clear engine owns initialisation
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[ptr] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!rd_oor) rd_word = mem[rd_addr];
        rd_merged = rd_word;
        if (RDW_MODE && wr_hit && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) rd_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            err      <= (wr_acc && wr_oor) || (rd_acc && rd_oor);
            if (rd_acc) rd_data <= rd_merged;
        end
    end

endmodule

// File: tb/tb_mem_rw_bank.sv
// Bench for mem_rw_bank: two banks (write-through and old-data policies) share one
// stimulus stream; a queue-based scoreboard checks them against an array model.
`timescale 1ns/1ps
module tb_mem_rw_bank;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 200;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0, rd_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [3:0]        wr_be = '0;

    logic              rd_valid_a, ready_a, init_busy_a, err_a;
    logic              rd_valid_b, ready_b, init_busy_b, err_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;

    mem_rw_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)) u_wt (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_a),
        .rd_data(rd_data_a), .ready(ready_a), .init_busy(init_busy_a), .err(err_a));

    mem_rw_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)) u_old (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_b),
        .rd_data(rd_data_b), .ready(ready_b), .init_busy(init_busy_b), .err(err_b));

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          e;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    exp_t        cq[$];
    logic [31:0] mdl [DEPTH];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          in_clear = 1'b1;
    bit          final_req = 1'b0;
    int          clr_cnt = 0;
    logic [31:0] last_a = '0, last_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: reset values, clear-phase quietness, then per-cycle scoreboard pops
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            chk("reset_flags", 32'({rd_valid_a, err_a, ready_a, init_busy_a,
                                    rd_valid_b, err_b, ready_b, init_busy_b}), 32'h11);
            chk("reset_rdata_wt", rd_data_a, 32'h0);
            chk("reset_rdata_old", rd_data_b, 32'h0);
            in_clear = 1'b1;
            clr_cnt  = 0;
            last_a   = '0;
            last_b   = '0;
        end else if (in_clear) begin
            clr_cnt++;
            if (ready_a) begin
                chk("clear_cycles", 32'(clr_cnt), 32'(DEPTH));
                chk("clear_done_flags", 32'({ready_b, init_busy_a, init_busy_b,
                                             rd_valid_a, rd_valid_b, err_a, err_b}), 32'h40);
                in_clear = 1'b0;
            end else if (clr_cnt <= DEPTH + 8) begin
                chk("clear_quiet", 32'({ready_b, init_busy_a, init_busy_b,
                                        rd_valid_a, rd_valid_b, err_a, err_b}), 32'h30);
            end
        end else begin
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("valid_err", 32'({rd_valid_a, rd_valid_b, err_a, err_b, ready_b, init_busy_b}),
                    32'({e.v, e.v, e.e, e.e, 1'b1, 1'b0}));
                if (e.v) begin
                    chk("rdata_wt", rd_data_a, e.da);
                    chk("rdata_old", rd_data_b, e.db);
                    last_a = e.da;
                    last_b = e.db;
                end else begin
                    chk("hold_wt", rd_data_a, last_a);
                    chk("hold_old", rd_data_b, last_b);
                end
            end else begin
                chk("idle", 32'({rd_valid_a, rd_valid_b, err_a, err_b}), 32'h0);
                chk("idle_hold_wt", rd_data_a, last_a);
                chk("idle_hold_old", rd_data_b, last_b);
            end
            if (final_req) chk("queue_drained", 32'(cq.size()), 32'h0);
        end
    end

    task automatic cycle(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input bit re, input logic [7:0] ra);
        exp_t        e;
        logic [31:0] old_w, new_w;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        old_w = '0;
        if (int'(ra) < DEPTH) old_w = mdl[ra];
        new_w = old_w;
        if (we && wa == ra && int'(ra) < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
        e.v  = re;
        e.e  = (we && int'(wa) >= DEPTH) || (re && int'(ra) >= DEPTH);
        e.da = re ? new_w : 32'h0;
        e.db = re ? old_w : 32'h0;
        cq.push_back(e);
        if (we && int'(wa) < DEPTH)
            for (int i = 0; i < 4; i++) if (be[i]) mdl[wa][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic idle();
        cycle(1'b0, 8'd0, 32'h0, 4'h0, 1'b0, 8'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2 * DEPTH + 50; i++) begin
            @(posedge clk);
            #2;
            if (ready_a) break;
        end
        if (!ready_a) begin
            $display("FAIL ready_timeout: ready still %b after budget", ready_a);
            $fatal(1, "ready never rose");
        end
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    task automatic hammer_inputs();
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd5;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        hammer_inputs();
        rst_n = 1'b1;
        wait_ready();

        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd5);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd199);
        cycle(1, 8'd3, 32'hAABBCCDD, 4'hF, 0, 8'd0);
        cycle(1, 8'd3, 32'h11223344, 4'b0101, 0, 8'd0);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd3);
        cycle(1, 8'd5, 32'h05, 4'h1, 0, 8'd0);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd5);
        cycle(1, 8'd5, 32'h00, 4'h1, 0, 8'd0);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd5);
        cycle(1, 8'd7, 32'h12, 4'h1, 0, 8'd0);
        cycle(1, 8'd7, 32'h34, 4'h1, 1, 8'd7);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd7);
        cycle(1, 8'd210, 32'hDEADBEEF, 4'hF, 0, 8'd0);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd250);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd199);
        cycle(1, 8'd220, 32'hCAFEF00D, 4'hF, 1, 8'd230);
        cycle(1, 8'd199, 32'hFFFFFFFF, 4'h0, 1, 8'd199);
        cycle(1, 8'd199, 32'h87654321, 4'b1010, 1, 8'd199);
        for (int a = 0; a < 10; a++) cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'(a));
        idle();
        idle();

        for (int n = 0; n < 600; n++) begin
            logic [7:0] wa, ra;
            wa = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 (($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 63)));
            cycle($urandom_range(0, 3) != 0, wa, $urandom, 4'($urandom), $urandom_range(0, 3) != 0, ra);
        end
        idle();
        idle();

        cycle(1, 8'd9, 32'h5A5A5A5A, 4'hF, 0, 8'd0);
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        hammer_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();

        for (int a = 0; a < 64; a++) cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'(a));
        cycle(0, 8'd0, 32'h0, 4'h0, 1, 8'd199);
        idle();
        idle();
        final_req = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_rw_bank.md
# mem_rw_bank

Parametrised single-clock memory bank with one write port and one read port. It has per-byte write enables and a registered read with 1-cycle latency. The read-during-write collision policy is selectable. A post-reset clear engine zero-fills the array and reports completion. The bank replaces bare unpacked-array memories wherever the design needs deterministic contents after reset and concurrent read/write access.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- DEPTH, 256: number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH): address width.
- RDW_MODE, 0: same-address read/write collision policy. 0 returns the old word; 1 returns the new word (write-through, byte-merged).
- CLEAR_ON_RESET, 1: 1 zero-fills the array after reset; 0 skips the clear and leaves contents undefined.

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request this cycle.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- rd_en  in  1  read request this cycle.
- rd_addr  in  ADDR_W  read word address.
- rd_valid  out  1  read data valid; a 1-cycle pulse.
- rd_data  out  DATA_W  read data; holds its value until the next accepted read.
- ready  out  1  bank accepts requests; low while clearing.
- init_busy  out  1  clear engine active.
- err  out  1  1-cycle pulse on any accepted out-of-range access (addr >= DEPTH).

## Operation
- Reset values:
  - rd_valid=0, rd_data=0, err=0.
  - ready=!CLEAR_ON_RESET.
  - init_busy=CLEAR_ON_RESET.
  - Clear pointer=0.
  - The array itself is not reset.
- State machine with two states, CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
  - CLEAR writes 0 to address ptr and increments ptr each cycle.
  - On the cycle that writes DEPTH-1, the next state is RUN, ptr returns to 0, and init_busy/ready switch on the same edge.
- CLEAR takes exactly DEPTH cycles after rst_n rises.
- In CLEAR, wr_en and rd_en are ignored: no array change, no rd_valid, no err.
- A write is accepted when ready && wr_en.
  - For each i with wr_be[i]=1, byte i of mem[wr_addr] takes wr_data byte i.
  - Other bytes are unchanged.
  - wr_be=0 is a legal no-op.
- A read is accepted when ready && rd_en.
  - Next cycle: rd_valid=1 and rd_data=mem[rd_addr] as sampled at the accept edge.
  - A read and a write may both be accepted in the same cycle.
- Collision: same-cycle read and write to the same in-range address.
  - RDW_MODE=0: rd_data is the pre-write word.
  - RDW_MODE=1: rd_data is the pre-write word with enabled bytes replaced by wr_data.
- Out-of-range accesses:
  - Out-of-range write: dropped, err pulses.
  - Out-of-range read: rd_valid pulses with rd_data=0, err pulses.
  - Both out of range in the same cycle: a single err pulse.
- Back-to-back reads every cycle are supported: rd_valid stays high continuously and rd_data updates each cycle.
- Reset asserted mid-CLEAR or mid-RUN:
  - All outputs immediately take their reset values.
  - Clearing restarts from address 0 after release.
  - A pending read response is discarded.

## Timing
- Read latency is 1 cycle from the accept edge to rd_valid/rd_data.
- Write data is visible to a read accepted on the next cycle, or the same cycle if RDW_MODE=1.
- ready, init_busy, rd_valid, rd_data and err are all registered; there is no combinational input-to-output path.
- Throughput is 1 read + 1 write per cycle in RUN.
- The first request can be accepted DEPTH cycles after rst_n rises (CLEAR_ON_RESET=1), or on the first edge after release (CLEAR_ON_RESET=0).

## Test plan
- Reset clear, default params:
  - Release rst_n; count cycles until ready=1, which must be 256.
  - Then read addr 5 -> rd_valid next cycle with rd_data=0; read addr 255 -> 0.
- Write/read, default params:
  - Write 0x05 to addr 5 with wr_be=1, then read addr 5 next cycle -> 0x05.
  - Overwrite with 0x00, read -> 0x00.
- Byte enables, DATA_W=32:
  - Write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101.
  - Read addr 3 -> 0xAA22CC44.
- Collision, same word written and read in the same cycle:
  - Addr 7 holds 0x12; write 0x34 be=1 to addr 7 while reading addr 7.
  - RDW_MODE=0 -> rd_data=0x12; RDW_MODE=1 -> rd_data=0x34.
  - A following read returns 0x34 in both modes.
- Out of range, DEPTH=200:
  - Write addr 210 -> err pulses once, no array change.
  - Read addr 250 -> rd_valid=1, rd_data=0, err=1.
  - Read addr 199 -> err=0.
- Reset mid-clear:
  - Assert rst_n low at clear cycle 100 while driving rd_en=1 throughout; release.
  - ready stays 0 for 256 full cycles after release, with no rd_valid during clear.
